// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 host-command scheduler.
// Holds the keyboard command/response bytes, FSM state, requester and error enums.
package kbd_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_SEND_ARG,
    ST_WAIT_TX,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_INIT,
    REQ_LED,
    REQ_RATE
  } req_t;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_RETRY       = 2'd1,
    ERR_BAT_FAIL    = 2'd2,
    ERR_BAT_TIMEOUT = 2'd3
  } err_t;

  function automatic logic [7:0] cmd_byte(input req_t r);
    case (r)
      REQ_INIT: cmd_byte = CMD_RESET;
      REQ_LED:  cmd_byte = CMD_SET_LED;
      REQ_RATE: cmd_byte = CMD_SET_RATE;
      default:  cmd_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/kbd_cmd_timer.sv
// Loadable down-counter; expire is high while enabled and the count has reached zero.
// The count saturates at zero so an expiry that loses to a received byte is seen again.
module kbd_cmd_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count;

  assign expire = en && !load && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/kbd_cmd_sched.sv
// Arbitrates init/LED/typematic requests and sequences each command byte onto kbd_ctrl,
// handling ACK/RESEND/BAT responses with retries, and forwarding all other received bytes.
module kbd_cmd_sched
  import kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned BAT_CYC     = 40_000_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_req,
  input  logic       led_req,
  input  logic [2:0] led_val,
  input  logic       rate_req,
  input  logic [7:0] rate_val,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_done,
  input  logic       tx_fail,
  input  logic [7:0] scode,
  input  logic       scode_en,
  output logic [7:0] fwd_code,
  output logic       fwd_en,
  output logic       busy,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic [1:0] err_code,
  output logic [2:0] led_state
);

  localparam int unsigned TMAX = (BAT_CYC > TIMEOUT_CYC) ? BAT_CYC : TIMEOUT_CYC;
  localparam int TW = $clog2(TMAX);
  localparam int RW = $clog2(MAX_RETRY + 2);

  state_t        state;
  req_t          cur;
  err_t          err_q;
  logic [7:0]    arg;
  logic          arg_phase;
  logic [RW-1:0] retry;
  logic          pend_init, pend_led, pend_rate;

  req_t          gnt_req;
  logic          gnt_fire;
  logic [7:0]    gnt_arg;
  logic          ack_ev, resend_ev, retry_max, consumed, init_ok;
  logic          tmr_load, tmr_en, tmr_expire;
  logic [TW-1:0] tmr_val;

  assign err_code = err_q;

  // Fixed priority: init > led > rate.
  always_comb begin
    gnt_req = REQ_NONE;
    gnt_arg = 8'h00;
    if (pend_init) begin
      gnt_req = REQ_INIT;
    end else if (pend_led) begin
      gnt_req = REQ_LED;
      gnt_arg = {5'b0, led_val};
    end else if (pend_rate) begin
      gnt_req = REQ_RATE;
      gnt_arg = rate_val;
    end
  end

  assign gnt_fire = (state == ST_IDLE) && (gnt_req != REQ_NONE);

  // A received byte takes precedence over a timeout expiring in the same cycle.
  always_comb begin
    ack_ev    = (state == ST_WAIT_ACK) && scode_en && (scode == RSP_ACK);
    resend_ev = ((state == ST_WAIT_TX) && !tx_done && tx_fail) ||
                ((state == ST_WAIT_ACK) && (scode_en ? (scode == RSP_RESEND) : tmr_expire));
    retry_max = (retry == RW'(MAX_RETRY));
    init_ok   = (state == ST_WAIT_BAT) && scode_en && (scode == RSP_BAT_OK);
    consumed  = ((state == ST_WAIT_ACK) && ((scode == RSP_ACK) || (scode == RSP_RESEND))) ||
                ((state == ST_WAIT_BAT) && ((scode == RSP_BAT_OK) || (scode == RSP_BAT_FAIL)));
    tmr_load  = ((state == ST_WAIT_TX) && tx_done) ||
                (ack_ev && !arg_phase && (cur == REQ_INIT));
    tmr_val   = (state == ST_WAIT_ACK) ? TW'(BAT_CYC - 1) : TW'(TIMEOUT_CYC - 1);
    tmr_en    = (state == ST_WAIT_ACK) || (state == ST_WAIT_BAT);
  end

  kbd_cmd_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expire   (tmr_expire)
  );

  // Sticky request flags; a pulse coinciding with its own grant is absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_init <= 1'b0;
      pend_led  <= 1'b0;
      pend_rate <= 1'b0;
    end else begin
      pend_init <= (pend_init | init_req) & ~(gnt_fire && (gnt_req == REQ_INIT));
      pend_led  <= (pend_led | led_req) & ~(gnt_fire && (gnt_req == REQ_LED)) & ~init_ok;
      pend_rate <= (pend_rate | rate_req) & ~(gnt_fire && (gnt_req == REQ_RATE));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_en   <= 1'b0;
      fwd_code <= 8'h00;
    end else begin
      fwd_en <= scode_en && !consumed;
      if (scode_en) fwd_code <= scode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur       <= REQ_NONE;
      err_q     <= ERR_NONE;
      arg       <= 8'h00;
      arg_phase <= 1'b0;
      retry     <= '0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
      led_state <= 3'b000;
    end else begin
      tx_start <= 1'b0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      if (resend_ev) begin
        if (retry_max) begin
          state   <= ST_ERR;
          err_q   <= ERR_RETRY;
          cmd_err <= 1'b1;
        end else begin
          retry    <= retry + RW'(1);
          tx_start <= 1'b1;
          state    <= arg_phase ? ST_SEND_ARG : ST_SEND_CMD;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (gnt_fire) begin
              cur       <= gnt_req;
              arg       <= gnt_arg;
              arg_phase <= 1'b0;
              retry     <= '0;
              err_q     <= ERR_NONE;
              tx_data   <= cmd_byte(gnt_req);
              tx_start  <= 1'b1;
              busy      <= 1'b1;
              state     <= ST_SEND_CMD;
            end
          end
          ST_SEND_CMD, ST_SEND_ARG: state <= ST_WAIT_TX;
          ST_WAIT_TX: begin
            if (tx_done) state <= ST_WAIT_ACK;
          end
          ST_WAIT_ACK: begin
            if (ack_ev) begin
              retry <= '0;
              if (arg_phase) begin
                if (cur == REQ_LED) led_state <= arg[2:0];
                cmd_done <= 1'b1;
                state    <= ST_DONE;
              end else if (cur == REQ_INIT) begin
                state <= ST_WAIT_BAT;
              end else begin
                arg_phase <= 1'b1;
                tx_data   <= arg;
                tx_start  <= 1'b1;
                state     <= ST_SEND_ARG;
              end
            end
          end
          ST_WAIT_BAT: begin
            if (init_ok) begin
              led_state <= 3'b000;
              cmd_done  <= 1'b1;
              state     <= ST_DONE;
            end else if (scode_en && (scode == RSP_BAT_FAIL)) begin
              err_q   <= ERR_BAT_FAIL;
              cmd_err <= 1'b1;
              state   <= ST_ERR;
            end else if (!scode_en && tmr_expire) begin
              err_q   <= ERR_BAT_TIMEOUT;
              cmd_err <= 1'b1;
              state   <= ST_ERR;
            end
          end
          ST_DONE, ST_ERR: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kbd_cmd_sched.sv
// Directed bench for kbd_cmd_sched: a kbd_ctrl transmitter model, scripted keyboard replies,
// and a scoreboard of bytes expected on the forwarding port.
`timescale 1ns/1ps
module tb_kbd_cmd_sched;

  logic       clk;
  logic       rst_n;
  logic       init_req, led_req, rate_req;
  logic [2:0] led_val;
  logic [7:0] rate_val;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done = 1'b0;
  logic       tx_fail = 1'b0;
  logic [7:0] scode;
  logic       scode_en;
  logic [7:0] fwd_code;
  logic       fwd_en;
  logic       busy, cmd_done, cmd_err;
  logic [1:0] err_code;
  logic [2:0] led_state;

  int checks = 0;
  int errors = 0;
  int tx_done_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int tx_num = 0;
  int tx_delay = 0;
  int fail_budget = 0;
  int fail_used = 0;
  logic [63:0] tx_hist = '0;
  logic [7:0] exp_b;
  logic [7:0] exp_q[$];

  kbd_cmd_sched #(.TIMEOUT_CYC(100), .BAT_CYC(1000), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_req(init_req), .led_req(led_req), .led_val(led_val),
    .rate_req(rate_req), .rate_val(rate_val),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .tx_fail(tx_fail),
    .scode(scode), .scode_en(scode_en),
    .fwd_code(fwd_code), .fwd_en(fwd_en),
    .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
    .err_code(err_code), .led_state(led_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish, required end before 800 us");
    $fatal(1, "watchdog expired");
  end

  // transmitter model, event counters and forwarding scoreboard
  always @(negedge clk) begin
    tx_done = 1'b0;
    tx_fail = 1'b0;
    if (rst_n) begin
      if (tx_delay > 0) begin
        tx_delay--;
        if (tx_delay == 0) begin
          if (fail_used < fail_budget) begin
            tx_fail = 1'b1;
            fail_used++;
          end else begin
            tx_done = 1'b1;
            tx_done_cnt++;
          end
        end
      end
      if (tx_start) begin
        tx_hist = {tx_hist[55:0], tx_data};
        tx_num++;
        tx_delay = 3;
      end
      if (cmd_done) done_cnt++;
      if (cmd_err) err_cnt++;
      if (fwd_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL fwd_unexpected: got %h, required no forward", fwd_code);
        end else begin
          exp_b = exp_q.pop_front();
          if (fwd_code !== exp_b) begin
            errors++;
            $display("FAIL fwd_code: got %h, required %h", fwd_code, exp_b);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    scode    = b;
    scode_en = 1'b1;
    @(negedge clk);
    scode_en = 1'b0;
  endtask

  task automatic wait_evt(input int kind, input int target, input int budget, input string name);
    int n;
    int cur;
    n = 0;
    cur = (kind == 0) ? tx_done_cnt : (kind == 1) ? done_cnt : err_cnt;
    while (cur < target && n < budget) begin
      @(negedge clk);
      n++;
      cur = (kind == 0) ? tx_done_cnt : (kind == 1) ? done_cnt : err_cnt;
    end
    checks++;
    if (cur < target) begin
      errors++;
      $display("FAIL %s: event count %0d, required %0d within %0d cycles", name, cur, target, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_start, busy, cmd_done, cmd_err, fwd_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000", {tx_start, busy, cmd_done, cmd_err, fwd_en});
    end
    checks++;
    if ({tx_data, fwd_code} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0000", {tx_data, fwd_code});
    end
    checks++;
    if ({err_code, led_state} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: got %b, required 00000", {err_code, led_state});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy %b tx_start %b, required 0 0", busy, tx_start);
    end
  endtask

  task automatic test_led();
    int tb0 = tx_num;
    int eb = tx_done_cnt;
    int db = done_cnt;
    led_val = 3'b101;
    led_req = 1'b1;
    @(negedge clk);
    led_req = 1'b0;
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL led_pending: busy %b tx_start %b, required 0 0", busy, tx_start);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hED || busy !== 1'b1) begin
      errors++;
      $display("FAIL led_grant: tx_start %b data %h busy %b, required 1 ed 1", tx_start, tx_data, busy);
    end
    led_val = 3'b010;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL led_start_pulse: tx_start %b, required 0", tx_start);
    end
    wait_evt(0, eb + 1, 50, "led_tx1");
    repeat (3) @(negedge clk);
    send_byte(8'hFA);
    wait_evt(0, eb + 2, 50, "led_tx2");
    repeat (3) @(negedge clk);
    send_byte(8'hFA);
    wait_evt(1, db + 1, 50, "led_done");
    repeat (2) @(negedge clk);
    checks++;
    if (tx_num - tb0 != 2 || tx_hist[15:0] !== 16'hED05) begin
      errors++;
      $display("FAIL led_bytes: got %0d bytes %h, required 2 bytes ed05", tx_num - tb0, tx_hist[15:0]);
    end
    checks++;
    if (led_state !== 3'b101 || busy !== 1'b0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL led_result: led %b busy %b err %0d, required 101 0 0", led_state, busy, err_code);
    end
  endtask

  task automatic test_tx_fail();
    int tb0 = tx_num;
    int eb = tx_done_cnt;
    int db = done_cnt;
    fail_budget++;
    led_val = 3'b110;
    led_req = 1'b1;
    @(negedge clk);
    led_req = 1'b0;
    wait_evt(0, eb + 1, 60, "fail_tx1");
    repeat (3) @(negedge clk);
    send_byte(8'hFA);
    wait_evt(0, eb + 2, 50, "fail_tx2");
    repeat (3) @(negedge clk);
    send_byte(8'hFA);
    wait_evt(1, db + 1, 50, "fail_done");
    repeat (2) @(negedge clk);
    checks++;
    if (tx_num - tb0 != 3 || tx_hist[23:0] !== 24'hEDED06) begin
      errors++;
      $display("FAIL fail_bytes: got %0d bytes %h, required 3 bytes eded06", tx_num - tb0, tx_hist[23:0]);
    end
    checks++;
    if (led_state !== 3'b110) begin
      errors++;
      $display("FAIL fail_led: got %b, required 110", led_state);
    end
  endtask

  task automatic test_no_response();
    int tb0 = tx_num;
    int db = done_cnt;
    int rb = err_cnt;
    led_val = 3'b001;
    led_req = 1'b1;
    @(negedge clk);
    led_req = 1'b0;
    wait_evt(2, rb + 1, 1500, "noresp_err");
    repeat (2) @(negedge clk);
    checks++;
    if (tx_num - tb0 != 4 || tx_hist[31:0] !== 32'hEDEDEDED) begin
      errors++;
      $display("FAIL noresp_bytes: got %0d bytes %h, required 4 bytes edededed", tx_num - tb0, tx_hist[31:0]);
    end
    checks++;
    if (err_code !== 2'd1 || busy !== 1'b0 || done_cnt != db) begin
      errors++;
      $display("FAIL noresp_result: err %0d busy %b dones %0d, required 1 0 0", err_code, busy, done_cnt - db);
    end
    checks++;
    if (led_state !== 3'b110) begin
      errors++;
      $display("FAIL noresp_led: got %b, required 110", led_state);
    end
  endtask

  task automatic test_rate_resend();
    int tb0 = tx_num;
    int eb = tx_done_cnt;
    int db = done_cnt;
    rate_val = 8'h20;
    rate_req = 1'b1;
    @(negedge clk);
    rate_req = 1'b0;
    @(negedge clk);
    checks++;
    if (err_code !== 2'd0 || tx_data !== 8'hF3) begin
      errors++;
      $display("FAIL rate_grant: err %0d data %h, required 0 f3", err_code, tx_data);
    end
    rate_val = 8'h55;
    wait_evt(0, eb + 1, 50, "rate_tx1");
    repeat (3) @(negedge clk);
    send_byte(8'hFE);
    wait_evt(0, eb + 2, 50, "rate_tx2");
    repeat (3) @(negedge clk);
    send_byte(8'hFE);
    wait_evt(0, eb + 3, 50, "rate_tx3");
    repeat (3) @(negedge clk);
    send_byte(8'hFA);
    wait_evt(0, eb + 4, 50, "rate_tx4");
    repeat (3) @(negedge clk);
    send_byte(8'hFA);
    wait_evt(1, db + 1, 50, "rate_done");
    repeat (2) @(negedge clk);
    checks++;
    if (tx_num - tb0 != 4 || tx_hist[31:0] !== 32'hF3F3F320) begin
      errors++;
      $display("FAIL rate_bytes: got %0d bytes %h, required 4 bytes f3f3f320", tx_num - tb0, tx_hist[31:0]);
    end
  endtask

  task automatic test_init();
    int tb0 = tx_num;
    int eb = tx_done_cnt;
    int db = done_cnt;
    int rb = err_cnt;
    int n;
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    wait_evt(0, eb + 1, 50, "init_tx1");
    repeat (3) @(negedge clk);
    send_byte(8'hFA);
    repeat (200) @(negedge clk);
    send_byte(8'hAA);
    wait_evt(1, db + 1, 50, "init_done");
    repeat (2) @(negedge clk);
    checks++;
    if (tx_num - tb0 != 1 || tx_hist[7:0] !== 8'hFF || led_state !== 3'b000) begin
      errors++;
      $display("FAIL init_ok: %0d bytes %h led %b, required 1 byte ff led 000", tx_num - tb0, tx_hist[7:0], led_state);
    end
    // BAT failure
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    wait_evt(0, eb + 2, 50, "batfail_tx");
    repeat (3) @(negedge clk);
    send_byte(8'hFA);
    repeat (50) @(negedge clk);
    send_byte(8'hFC);
    wait_evt(2, rb + 1, 50, "batfail_err");
    repeat (2) @(negedge clk);
    checks++;
    if (err_code !== 2'd2 || done_cnt != db + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL batfail_result: err %0d dones %0d busy %b, required 2 1 0", err_code, done_cnt - db, busy);
    end
    // BAT timeout: cmd_err seen on the 1000th falling edge after the ACK cycle
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    wait_evt(0, eb + 3, 50, "batto_tx");
    repeat (3) @(negedge clk);
    send_byte(8'hFA);
    n = 0;
    while (cmd_err !== 1'b1 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 1000) begin
      errors++;
      $display("FAIL batto_latency: cmd_err after %0d cycles, required 1000", n);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (err_code !== 2'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL batto_result: err %0d busy %b, required 3 0", err_code, busy);
    end
  endtask

  task automatic test_priority();
    int tb0 = tx_num;
    int eb = tx_done_cnt;
    int db = done_cnt;
    led_val  = 3'b111;
    rate_val = 8'h33;
    init_req = 1'b1;
    led_req  = 1'b1;
    rate_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    led_req  = 1'b0;
    rate_req = 1'b0;
    wait_evt(0, eb + 1, 50, "prio_tx1");
    repeat (3) @(negedge clk);
    send_byte(8'hFA);
    repeat (20) @(negedge clk);
    send_byte(8'hAA);
    wait_evt(0, eb + 2, 50, "prio_tx2");
    repeat (3) @(negedge clk);
    send_byte(8'hFA);
    wait_evt(0, eb + 3, 50, "prio_tx3");
    repeat (3) @(negedge clk);
    send_byte(8'hFA);
    wait_evt(1, db + 2, 50, "prio_done");
    repeat (20) @(negedge clk);
    checks++;
    if (tx_num - tb0 != 3 || tx_hist[23:0] !== 24'hFFF333) begin
      errors++;
      $display("FAIL prio_bytes: got %0d bytes %h, required 3 bytes fff333", tx_num - tb0, tx_hist[23:0]);
    end
    checks++;
    if (busy !== 1'b0 || led_state !== 3'b000) begin
      errors++;
      $display("FAIL prio_result: busy %b led %b, required 0 000", busy, led_state);
    end
  endtask

  task automatic test_forward();
    int eb = tx_done_cnt;
    int db = done_cnt;
    exp_q.push_back(8'h1C);
    send_byte(8'h1C);
    checks++;
    if (fwd_en !== 1'b1 || fwd_code !== 8'h1C) begin
      errors++;
      $display("FAIL fwd_idle: en %b code %h, required 1 1c", fwd_en, fwd_code);
    end
    @(negedge clk);
    checks++;
    if (fwd_en !== 1'b0) begin
      errors++;
      $display("FAIL fwd_pulse: en %b, required 0", fwd_en);
    end
    exp_q.push_back(8'hFA);
    send_byte(8'hFA);
    checks++;
    if (fwd_en !== 1'b1 || fwd_code !== 8'hFA) begin
      errors++;
      $display("FAIL fwd_stray_ack: en %b code %h, required 1 fa", fwd_en, fwd_code);
    end
    led_val = 3'b100;
    led_req = 1'b1;
    @(negedge clk);
    led_req = 1'b0;
    wait_evt(0, eb + 1, 50, "fwd_tx1");
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h1C);
    send_byte(8'h1C);
    checks++;
    if (fwd_en !== 1'b1 || fwd_code !== 8'h1C || busy !== 1'b1) begin
      errors++;
      $display("FAIL fwd_wait_ack: en %b code %h busy %b, required 1 1c 1", fwd_en, fwd_code, busy);
    end
    @(negedge clk);
    send_byte(8'hFA);
    checks++;
    if (fwd_en !== 1'b0) begin
      errors++;
      $display("FAIL fwd_ack_consumed: en %b, required 0", fwd_en);
    end
    wait_evt(0, eb + 2, 50, "fwd_tx2");
    repeat (3) @(negedge clk);
    send_byte(8'hFA);
    wait_evt(1, db + 1, 50, "fwd_done");
    repeat (2) @(negedge clk);
    checks++;
    if (tx_hist[15:0] !== 16'hED04 || led_state !== 3'b100) begin
      errors++;
      $display("FAIL fwd_cmd: bytes %h led %b, required ed04 100", tx_hist[15:0], led_state);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    init_req = 1'b0;
    led_req  = 1'b0;
    rate_req = 1'b0;
    led_val  = 3'b000;
    rate_val = 8'h00;
    scode    = 8'h00;
    scode_en = 1'b0;
    test_reset();
    test_led();
    test_tx_fail();
    test_no_response();
    test_rate_resend();
    test_init();
    test_priority();
    test_forward();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL fwd_missing: %0d expected bytes never forwarded, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
